// File: rtl/icache_assoc_line_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// slave is the cache view; master is the IF / memory-controller view.
interface icache_assoc_line_if;
    logic        pc_valid_i;
    logic [31:0] pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_valid_i;
    logic [31:0] mem_data_i;

    modport slave (
        input  pc_valid_i, pc_i, mem_valid_i, mem_data_i,
        output inst_valid_o, inst_o, mem_req_o, mem_addr_o
    );

    modport master (
        output pc_valid_i, pc_i, mem_valid_i, mem_data_i,
        input  inst_valid_o, inst_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/icache_assoc_line.sv
// 1/2-way set-associative instruction cache with LRU, burst line refill and critical-word bypass.
// Define ICACHE_PERF_EN to add the hit_cnt_o / miss_cnt_o performance counters.
module icache_assoc_line #(
    parameter int unsigned WAYS     = 2,
    parameter int unsigned INDEX_W  = 6,
    parameter int unsigned OFFSET_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic flush,
    icache_assoc_line_if.slave bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);
    localparam int unsigned TAG_W = 30 - INDEX_W - OFFSET_W;
    localparam int unsigned SETS  = 1 << INDEX_W;
    localparam int unsigned WORDS = 1 << OFFSET_W;

    typedef enum logic {IDLE, REFILL} state_t;
    state_t state;

    logic [31:0]      data_mem [WAYS][SETS][WORDS];
    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [SETS-1:0]  valid    [WAYS];
    logic [SETS-1:0]  lru;

    logic [OFFSET_W-1:0] off;
    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;

    logic [INDEX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                fill_way;
    logic [OFFSET_W-1:0] cnt;
    logic                discard;
    logic                mem_req;
    logic [31:0]         mem_addr;

    logic        hit;
    logic        hit_way;
    logic [31:0] hit_data;
    logic        victim;
    logic        found_free;
    logic        bypass;
    logic        last;
    logic        fill_word;

    assign off = bus.pc_i[OFFSET_W+1:2];
    assign idx = bus.pc_i[OFFSET_W+INDEX_W+1:OFFSET_W+2];
    assign tag = bus.pc_i[31:OFFSET_W+INDEX_W+2];

    always_comb begin
        hit      = 1'b0;
        hit_way  = 1'b0;
        hit_data = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && valid[w][idx] && tag_mem[w][idx] == tag) begin
                hit      = bus.pc_valid_i;
                hit_way  = 1'(w);
                hit_data = data_mem[w][idx][off];
            end
        end
    end

    // Prefer the lowest-numbered empty way; only fall back to LRU when the set is full.
    always_comb begin
        victim     = (WAYS == 1) ? 1'b0 : lru[idx];
        found_free = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found_free && !valid[w][idx]) begin
                victim     = 1'(w);
                found_free = 1'b1;
            end
        end
    end

    assign last      = &cnt;
    assign fill_word = (state == REFILL) && bus.mem_valid_i;
    assign bypass    = fill_word && bus.pc_valid_i && (bus.pc_i[31:2] == mem_addr[31:2]);

    assign bus.inst_valid_o = hit || bypass;
    assign bus.inst_o       = hit ? hit_data : (bypass ? bus.mem_data_i : '0);
    assign bus.mem_req_o    = mem_req;
    assign bus.mem_addr_o   = mem_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            for (int unsigned w = 0; w < WAYS; w++) valid[w] <= '0;
            lru      <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            cnt      <= '0;
            discard  <= 1'b0;
            fill_idx <= '0;
            fill_tag <= '0;
            fill_way <= 1'b0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (bus.pc_valid_i && !hit) begin
                        state    <= REFILL;
                        fill_idx <= idx;
                        fill_tag <= tag;
                        fill_way <= victim;
                        mem_req  <= 1'b1;
                        mem_addr <= {bus.pc_i[31:OFFSET_W+2], (OFFSET_W+2)'(0)};
                        cnt      <= '0;
                    end else if (hit && !flush) begin
                        lru[idx] <= ~hit_way;
                    end
                end
                REFILL: begin
                    if (flush && !(bus.mem_valid_i && last)) discard <= 1'b1;
                    if (bus.mem_valid_i) begin
                        cnt      <= cnt + 1'b1;
                        mem_addr <= mem_addr + 32'd4;
                        if (last) begin
                            valid[fill_way][fill_idx] <= !discard;
                            lru[fill_idx]             <= ~fill_way;
                            mem_req                   <= 1'b0;
                            discard                   <= 1'b0;
                            state                     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed last so a flush overrides the valid set by a completing refill.
            if (flush) for (int unsigned w = 0; w < WAYS; w++) valid[w] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_word) begin
            data_mem[fill_way][fill_idx][cnt] <= bus.mem_data_i;
            if (last) tag_mem[fill_way][fill_idx] <= fill_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (rdy) begin
            if (hit) hit_cnt_o <= hit_cnt_o + 32'd1;
            if (state == IDLE && bus.pc_valid_i && !hit) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_assoc_line.sv
// Scoreboard bench for icache_assoc_line: fetch stimulus pushes expected words, a negedge monitor pops them.
module tb_icache_assoc_line;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic flush = 1'b0;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned exp_hits = 0;
    int unsigned exp_misses = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    icache_assoc_line_if bus();

    icache_assoc_line #(.WAYS(2), .INDEX_W(6), .OFFSET_W(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.inst_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_inst: got %h expected no valid instruction", bus.inst_o);
            end else begin
                check("inst", bus.inst_o, exp_q.pop_front());
            end
        end
    end

    task automatic fetch_hit(input logic [31:0] a);
        bus.pc_i = a;
        bus.pc_valid_i = 1'b1;
        exp_q.push_back(mem_word(a));
        exp_hits++;
        tick();
        bus.pc_valid_i = 1'b0;
        check($sformatf("hit_%0h_served", a), 32'(exp_q.size()), 32'd0);
    endtask

    task automatic fetch_miss(input logic [31:0] a);
        bus.pc_i = a;
        bus.pc_valid_i = 1'b1;
        tick();
        bus.pc_valid_i = 1'b0;
        exp_misses++;
        check($sformatf("miss_%0h_req", a), 32'(bus.mem_req_o), 32'd1);
        check($sformatf("miss_%0h_addr", a), bus.mem_addr_o, a & ~32'hF);
    endtask

    task automatic serve(input logic [31:0] base, input int unsigned first, input int unsigned last);
        for (int unsigned k = first; k <= last; k++) begin
            check("burst_addr", bus.mem_addr_o, base + 32'(4 * k));
            bus.mem_valid_i = 1'b1;
            bus.mem_data_i = mem_word(base + 32'(4 * k));
            tick();
            bus.mem_valid_i = 1'b0;
        end
        if (last == 3) check("req_drop", 32'(bus.mem_req_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.pc_i = '0;
        bus.pc_valid_i = 1'b0;
        bus.mem_valid_i = 1'b0;
        bus.mem_data_i = '0;
        repeat (3) tick();
        bus.pc_i = 32'h100;
        bus.pc_valid_i = 1'b1;
        #1;
        check("reset_inst_valid", 32'(bus.inst_valid_o), 32'd0);
        check("reset_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("reset_mem_addr", bus.mem_addr_o, 32'd0);
        bus.pc_valid_i = 1'b0;
        rst = 1'b0;
        tick();

        // cold miss, then a same-line hit
        fetch_miss(32'h100);
        serve(32'h100, 0, 3);
        fetch_hit(32'h104);

        // critical-word bypass: pc held on 0x208 through the whole burst
        bus.pc_i = 32'h208;
        bus.pc_valid_i = 1'b1;
        tick();
        exp_misses++;
        check("byp_req", 32'(bus.mem_req_o), 32'd1);
        for (int unsigned k = 0; k < 4; k++) begin
            check("byp_addr", bus.mem_addr_o, 32'h200 + 32'(4 * k));
            bus.mem_valid_i = 1'b1;
            bus.mem_data_i = mem_word(32'h200 + 32'(4 * k));
            if (k == 2) exp_q.push_back(mem_word(32'h208));
            tick();
            if (k == 2) check("byp_served", 32'(exp_q.size()), 32'd0);
        end
        bus.mem_valid_i = 1'b0;
        bus.pc_valid_i = 1'b0;
        fetch_hit(32'h20C);

        // LRU in set 0
        fetch_miss(32'h0000); serve(32'h0000, 0, 3);
        fetch_miss(32'h0400); serve(32'h0400, 0, 3);
        fetch_hit(32'h0000);
        fetch_miss(32'h0800); serve(32'h0800, 0, 3);
        fetch_hit(32'h0004);
        fetch_hit(32'h0808);
        fetch_miss(32'h0400); serve(32'h0400, 0, 3);

        // flush in IDLE
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fetch_miss(32'h100); serve(32'h100, 0, 3);
        fetch_hit(32'h10C);

        // flush mid-refill keeps the filling line invalid
        fetch_miss(32'h300);
        serve(32'h300, 0, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_mid_addr", bus.mem_addr_o, 32'h308);
        serve(32'h300, 2, 3);
        fetch_miss(32'h300); serve(32'h300, 0, 3);
        fetch_hit(32'h304);

        // rdy stall mid-refill
        fetch_miss(32'h500);
        serve(32'h500, 0, 0);
        rdy = 1'b0;
        for (int unsigned s = 0; s < 3; s++) begin
            tick();
            check("stall_addr", bus.mem_addr_o, 32'h504);
            check("stall_req", 32'(bus.mem_req_o), 32'd1);
        end
        rdy = 1'b1;
        serve(32'h500, 1, 3);
        fetch_hit(32'h50C);

        // reset mid-refill abandons the burst and invalidates everything
        fetch_miss(32'h600);
        serve(32'h600, 0, 0);
        rst = 1'b1;
        tick();
        check("rst_mid_req", 32'(bus.mem_req_o), 32'd0);
        check("rst_mid_addr", bus.mem_addr_o, 32'd0);
        rst = 1'b0;
        exp_hits = 0;
        exp_misses = 0;

        // counters: one miss, then three hits
        fetch_miss(32'h100); serve(32'h100, 0, 3);
        fetch_hit(32'h104);
        fetch_hit(32'h108);
        fetch_hit(32'h10C);
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef ICACHE_PERF_EN
        check("miss_cnt", miss_cnt, 32'(exp_misses));
        check("hit_cnt", hit_cnt, 32'(exp_hits));
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
